// File: rtl/arm_pipelined_conditional_unit.sv
// Execute-stage conditional unit: holds NZCV, evaluates the condition field, annuls
// failing instructions and registers the surviving controls into the Execute/Memory register.
module arm_pipelined_conditional_unit (
    input  logic        i_CLK,
    input  logic        i_NRESET,
    input  logic        i_Valid,
    input  logic        i_Stall_E,
    input  logic        i_Flush_M,
    input  logic [3:0]  i_Cond,
    input  logic [1:0]  i_FlagWrite,
    input  logic [3:0]  i_ALUFlags,
    input  logic        i_PCSrc,
    input  logic        i_RegWrite,
    input  logic        i_MemWrite,
    input  logic        i_MemToReg,
    input  logic        i_CntClr,
    output logic [3:0]  o_Flags,
    output logic        o_CondEx,
    output logic        o_PCSrc_E,
    output logic        o_PCSrc_M,
    output logic        o_RegWrite_M,
    output logic        o_MemWrite_M,
    output logic        o_MemToReg_M,
    output logic [15:0] o_AnnulCnt
);

    // ARM condition decode against {N,Z,C,V}; code F is reserved and never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]  flags_q;
    logic [3:0]  flags_d;
    logic [3:0]  ctrl_m_q;
    logic [3:0]  ctrl_m_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        cond_ex_s;
    logic        pcsrc_g_s;
    logic        regwrite_g_s;
    logic        memwrite_g_s;
    logic        commit_s;
    logic        annul_s;

    // Condition result and gated controls for the instruction currently in Execute.
    always_comb begin
        cond_ex_s    = i_Valid & cond_pass(i_Cond, flags_q);
        pcsrc_g_s    = i_PCSrc & cond_ex_s;
        regwrite_g_s = i_RegWrite & cond_ex_s;
        memwrite_g_s = i_MemWrite & cond_ex_s;
        commit_s     = cond_ex_s & ~i_Stall_E;
        annul_s      = i_Valid & ~cond_ex_s & ~i_Stall_E;
    end

    // Next flag value: N,Z and C,V halves load independently, only on an unstalled pass.
    always_comb begin
        flags_d = flags_q;
        if (commit_s && i_FlagWrite[1]) begin
            flags_d[3:2] = i_ALUFlags[3:2];
        end else begin
            flags_d[3:2] = flags_q[3:2];
        end
        if (commit_s && i_FlagWrite[0]) begin
            flags_d[1:0] = i_ALUFlags[1:0];
        end else begin
            flags_d[1:0] = flags_q[1:0];
        end
    end

    // Next Memory-stage controls; a stall or flush delivers a bubble downstream.
    always_comb begin
        ctrl_m_d = 4'b0000;
        if (i_Flush_M || i_Stall_E) begin
            ctrl_m_d = 4'b0000;
        end else begin
            ctrl_m_d = {pcsrc_g_s, regwrite_g_s, memwrite_g_s, i_MemToReg};
        end
    end

    // Next annul count: clear wins, otherwise saturating increment on each annulled slot.
    always_comb begin
        cnt_d = cnt_q;
        if (i_CntClr) begin
            cnt_d = 16'h0000;
        end else if (annul_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            flags_q  <= 4'b0000;
            ctrl_m_q <= 4'b0000;
            cnt_q    <= 16'h0000;
        end else begin
            flags_q  <= flags_d;
            ctrl_m_q <= ctrl_m_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_Flags      = flags_q;
    assign o_CondEx     = cond_ex_s;
    assign o_PCSrc_E    = pcsrc_g_s;
    assign o_PCSrc_M    = ctrl_m_q[3];
    assign o_RegWrite_M = ctrl_m_q[2];
    assign o_MemWrite_M = ctrl_m_q[1];
    assign o_MemToReg_M = ctrl_m_q[0];
    assign o_AnnulCnt   = cnt_q;

endmodule

// File: tb/tb_arm_pipelined_conditional_unit.sv
// Directed bench for arm_pipelined_conditional_unit: reference flag/counter model plus a
// queue of expected Memory-stage controls popped one cycle after each instruction.
module tb_arm_pipelined_conditional_unit;

    logic        clk;
    logic        nreset;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [3:0]  cond;
    logic [1:0]  fw;
    logic [3:0]  alu;
    logic        pcsrc;
    logic        regwrite;
    logic        memwrite;
    logic        memtoreg;
    logic        cntclr;
    logic [3:0]  flags_o;
    logic        condex_o;
    logic        pcsrc_e_o;
    logic        pcsrc_m_o;
    logic        regwrite_m_o;
    logic        memwrite_m_o;
    logic        memtoreg_m_o;
    logic [15:0] cnt_o;

    int          n_cmp;
    int          n_fail;
    logic [3:0]  m_flags;
    logic [15:0] m_cnt;
    logic [3:0]  exp_q[$];

    arm_pipelined_conditional_unit dut (
        .i_CLK        (clk),
        .i_NRESET     (nreset),
        .i_Valid      (valid),
        .i_Stall_E    (stall),
        .i_Flush_M    (flush),
        .i_Cond       (cond),
        .i_FlagWrite  (fw),
        .i_ALUFlags   (alu),
        .i_PCSrc      (pcsrc),
        .i_RegWrite   (regwrite),
        .i_MemWrite   (memwrite),
        .i_MemToReg   (memtoreg),
        .i_CntClr     (cntclr),
        .o_Flags      (flags_o),
        .o_CondEx     (condex_o),
        .o_PCSrc_E    (pcsrc_e_o),
        .o_PCSrc_M    (pcsrc_m_o),
        .o_RegWrite_M (regwrite_m_o),
        .o_MemWrite_M (memwrite_m_o),
        .o_MemToReg_M (memtoreg_m_o),
        .o_AnnulCnt   (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n;
        logic z;
        logic cy;
        logic v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z == 1'b1;
            4'h1: return z == 1'b0;
            4'h2: return cy == 1'b1;
            4'h3: return cy == 1'b0;
            4'h4: return n == 1'b1;
            4'h5: return n == 1'b0;
            4'h6: return v == 1'b1;
            4'h7: return v == 1'b0;
            4'h8: return (cy == 1'b1) && (z == 1'b0);
            4'h9: return (cy == 1'b0) || (z == 1'b1);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return (z == 1'b0) && (n == v);
            4'hD: return (z == 1'b1) || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        valid = 1'b0; stall = 1'b0; flush = 1'b0; cond = 4'hE; fw = 2'b00;
        alu = 4'h0; pcsrc = 1'b0; regwrite = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
        cntclr = 1'b0;
    endtask

    // One Execute cycle: drive, check combinational outputs, push expected *_M, clock, pop.
    task automatic step(input string tag, input logic v, input logic st, input logic fl,
                        input logic [3:0] c, input logic [1:0] w, input logic [3:0] a,
                        input logic pc, input logic rw, input logic mw, input logic m2r,
                        input logic clr);
        logic       cex;
        logic [3:0] em;
        @(negedge clk);
        valid = v; stall = st; flush = fl; cond = c; fw = w; alu = a;
        pcsrc = pc; regwrite = rw; memwrite = mw; memtoreg = m2r; cntclr = clr;
        #1;
        cex = v & ref_cond(c, m_flags);
        chk({tag, ".condex"}, {15'd0, condex_o}, {15'd0, cex});
        chk({tag, ".pcsrc_e"}, {15'd0, pcsrc_e_o}, {15'd0, pc & cex});
        chk({tag, ".flags_pre"}, {12'd0, flags_o}, {12'd0, m_flags});
        em = (st | fl) ? 4'b0000 : {pc & cex, rw & cex, mw & cex, m2r};
        exp_q.push_back(em);
        if (!st && cex) begin
            if (w[1]) m_flags[3:2] = a[3:2];
            if (w[0]) m_flags[1:0] = a[1:0];
        end
        if (clr) m_cnt = 16'h0000;
        else if (v && !cex && !st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
        @(posedge clk);
        #1;
        em = exp_q.pop_front();
        chk({tag, ".ctrl_m"}, {12'd0, pcsrc_m_o, regwrite_m_o, memwrite_m_o, memtoreg_m_o},
            {12'd0, em});
        chk({tag, ".flags"}, {12'd0, flags_o}, {12'd0, m_flags});
        chk({tag, ".cnt"}, cnt_o, m_cnt);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        m_flags = 4'b0000;
        m_cnt = 16'h0000;
        idle_inputs();
        nreset = 1'b0;
        #12;
        chk("reset.flags", {12'd0, flags_o}, 16'h0000);
        chk("reset.ctrl_m", {12'd0, pcsrc_m_o, regwrite_m_o, memwrite_m_o, memtoreg_m_o}, 16'h0000);
        chk("reset.cnt", cnt_o, 16'h0000);
        @(negedge clk);
        nreset = 1'b1;

        // EQ fails on cleared flags; NE and AL pass.
        step("eq_fail", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("eq_fail.cnt1", cnt_o, 16'h0001);
        step("ne_pass", 1'b1, 1'b0, 1'b0, 4'h1, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("al_setz", 1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("al_setz.flags0100", {12'd0, flags_o}, 16'h0004);
        step("eq_mw", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ne_fail", 1'b1, 1'b0, 1'b0, 4'h1, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Split update: only N,Z change.
        step("set0011", 1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("split", 1'b1, 1'b0, 1'b0, 4'hE, 2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("split.flags1011", {12'd0, flags_o}, 16'h000B);
        step("ge_pass", 1'b1, 1'b0, 1'b0, 4'hA, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lt_fail", 1'b1, 1'b0, 1'b0, 4'hB, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("bubble", 1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Stall then flush of the same flag-writing branch.
        step("stall", 1'b1, 1'b1, 1'b0, 4'hE, 2'b11, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stall_ann", 1'b1, 1'b1, 1'b0, 4'hF, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 1'b0, 1'b1, 4'hE, 2'b11, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush.flags0110", {12'd0, flags_o}, 16'h0006);

        // Sweep every condition code against two flag patterns.
        for (int p = 0; p < 2; p++) begin
            step("setpat", 1'b1, 1'b0, 1'b0, 4'hE, 2'b11, (p == 0) ? 4'b1010 : 4'b0101,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                step("sweep", 1'b1, 1'b0, 1'b0, c[3:0], 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            end
        end

        // Saturating counter: clear, preload to FFFE, two more annuls, then clear+annul.
        step("clr", 1'b1, 1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_inputs();
        valid = 1'b1;
        cond = 4'hF;
        repeat (65534) @(posedge clk);
        m_cnt = 16'hFFFE;
        #1;
        chk("preload.cnt", cnt_o, 16'hFFFE);
        step("sat1", 1'b1, 1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat1.ffff", cnt_o, 16'hFFFF);
        step("sat2", 1'b1, 1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat2.ffff", cnt_o, 16'hFFFF);
        step("clr_ann", 1'b1, 1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ann.zero", cnt_o, 16'h0000);

        // Asynchronous reset between edges with live state.
        step("pre_rst_a", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pre_rst_b", 1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("pre_rst.flags1111", {12'd0, flags_o}, 16'h000F);
        idle_inputs();
        #1;
        nreset = 1'b0;
        #1;
        chk("arst.flags", {12'd0, flags_o}, 16'h0000);
        chk("arst.ctrl_m", {12'd0, pcsrc_m_o, regwrite_m_o, memwrite_m_o, memtoreg_m_o}, 16'h0000);
        chk("arst.cnt", cnt_o, 16'h0000);
        chk("arst.comb", {14'd0, condex_o, pcsrc_e_o}, 16'h0000);
        m_flags = 4'b0000;
        m_cnt = 16'h0000;
        @(negedge clk);
        nreset = 1'b1;
        step("post_rst_eq", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("post_rst_al", 1'b1, 1'b0, 1'b0, 4'hE, 2'b01, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_pipelined_conditional_unit.md
# arm_pipelined_conditional_unit

Execute-stage conditional unit of the pipelined ARM core. Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it. It annuls the instruction's side effects (register write, memory write, PC redirect, flag update) when the condition fails, and registers the surviving control bits into the Execute/Memory pipeline register. It sits between the Decode/Execute pipeline register (upstream) and the Memory stage and hazard unit (downstream).

## Interface
- No parameters; the annul counter is fixed at 16 bits.
- i_CLK  in  1  rising-edge clock
- i_NRESET  in  1  asynchronous, active-low reset
- i_Valid  in  1  Execute slot holds a real instruction; 0 means bubble
- i_Stall_E  in  1  Execute stage stalled this cycle
- i_Flush_M  in  1  insert bubble into Memory stage
- i_Cond  in  4  instruction condition field [31:28]
- i_FlagWrite  in  2  bit1 = update N,Z; bit0 = update C,V
- i_ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle
- i_PCSrc, i_RegWrite, i_MemWrite, i_MemToReg  in  1 each  decoded controls in Execute
- i_CntClr  in  1  synchronous clear of annul counter
- o_Flags  out  4  current {N,Z,C,V} register
- o_CondEx  out  1  condition passed (combinational)
- o_PCSrc_E  out  1  gated branch redirect to hazard unit (combinational)
- o_PCSrc_M, o_RegWrite_M, o_MemWrite_M, o_MemToReg_M  out  1 each  registered gated controls
- o_AnnulCnt  out  16  count of annulled valid instructions

## Operation
- Condition evaluation uses o_Flags (N,Z,C,V):
  - EQ 0: Z. NE 1: !Z. HS 2: C. LO 3: !C. MI 4: N. PL 5: !N. VS 6: V. VC 7: !V.
  - HI 8: C&!Z. LS 9: !C|Z. GE A: N==V. LT B: N!=V. GT C: !Z&(N==V). LE D: Z|(N!=V).
  - AL E: 1. Code F: 0 (reserved, never executes).
- o_CondEx = i_Valid & condition result. A bubble never passes.
- Gated controls: X_g = i_X & o_CondEx for PCSrc, RegWrite, MemWrite. MemToReg passes ungated; it is harmless without RegWrite. o_PCSrc_E = PCSrc_g.
- Flag update at the clock edge when ~i_Stall_E & o_CondEx:
  - i_FlagWrite[1] loads N,Z from i_ALUFlags[3:2].
  - i_FlagWrite[0] loads C,V from i_ALUFlags[1:0].
  - The two halves are independent, so FlagWrite=2'b10 leaves C,V unchanged.
- No flag forwarding: flags written by instruction k are visible to instruction k+1 on the next cycle.
- Memory register load:
  - If i_Flush_M | i_Stall_E: load all zeros (bubble). Flush and stall are equivalent here.
  - Otherwise: load the gated controls.
- Annul counter:
  - Increments when i_Valid & ~o_CondEx & ~i_Stall_E.
  - Saturates at 16'hFFFF.
  - i_CntClr has priority over increment and forces 0.

## Timing
- Reset (asynchronous, i_NRESET=0): o_Flags=4'b0000, all *_M outputs 0, o_AnnulCnt=0. Release is synchronous to the next rising edge.
- With flags 0000 after reset: EQ fails, NE passes, AL passes.
- o_CondEx and o_PCSrc_E are combinational, same cycle as the inputs.
- *_M outputs have 1-cycle latency.
- Flags update at the same edge that captures the *_M outputs. The instruction in Execute during cycle t+1 sees them.
- A stalled cycle writes nothing: flags hold, the counter holds, and the Memory stage receives a bubble. The re-presented instruction evaluates again in the next unstalled cycle against unchanged flags.
- Flush_M never affects the flags or the counter. Flags commit only when the stall is low.
- Reset asserted mid-operation clears immediately. No pending update survives.

## Test plan
- Reset, then i_Valid=1, i_Cond=4'h0 (EQ), i_RegWrite=1 -> o_CondEx=0, o_RegWrite_M=0 next cycle, o_AnnulCnt=1.
- Flag update and use:
  - i_Cond=E, i_FlagWrite=2'b11, i_ALUFlags=4'b0100 -> o_Flags=0100 next cycle.
  - Then i_Cond=0 with i_MemWrite=1 -> o_MemWrite_M=1.
  - Then i_Cond=1 -> o_CondEx=0.
- Split update: flags 0011, i_FlagWrite=2'b10, i_ALUFlags=4'b1000 -> o_Flags=1011. Then GE (N=1,V=1) passes and LT fails.
- Stall and flush:
  - i_Stall_E=1 with a passing FlagWrite=11 instruction and i_PCSrc=1 -> o_PCSrc_E=1 combinationally. Flags unchanged, o_PCSrc_M=0.
  - Same instruction unstalled, i_Flush_M=1 -> flags update, *_M=0.
- Counter:
  - Preload 16'hFFFE via repeated annuls. Two more annuls -> 16'hFFFF and holds.
  - Annul and i_CntClr in the same cycle -> 0.
- Assert i_NRESET low between clock edges while flags=1111 and *_M nonzero -> all outputs 0 immediately, before the next edge.
